peripheral_responder: RTL and testbench
=======================================

// Module: peripheral_responder
// PURPOSE
//  Peripheral-side endpoint of the core I/O port. Takes requests from RISC_V_Core's
//  to_peripheral / to_peripheral_data / to_peripheral_valid and drives its
//  from_peripheral / from_peripheral_data / from_peripheral_valid responses.
//  Buffers outbound words in a TX FIFO and inbound host words in an RX FIFO.
//  Sits between the core and the board-level host/UART bridge.
// PARAMETERS
//  DATA_WIDTH  32   width of request/response data and FIFO entries
//  FIFO_DEPTH  4    entries per FIFO; power of two, >= 2
//  TIMEOUT     255  cycles a READ waits for RX data before an error response
// PORTS
//  clock                  in   1   single clock, rising edge
//  reset                  in   1   asynchronous, active-high
//  to_peripheral          in   2   request code: 00 none, 01 WRITE, 10 READ, 11 STATUS
//  to_peripheral_data     in   DW  WRITE payload, ignored for other codes
//  to_peripheral_valid    in   1   request strobe
//  from_peripheral        out  2   response code: 00 none, 01 ACK, 10 DATA, 11 ERROR
//  from_peripheral_data   out  DW  response payload
//  from_peripheral_valid  out  1   one-cycle response strobe
//  host_in_data           in   DW  word from host into RX FIFO
//  host_in_valid          in   1   host push request
//  host_in_ready          out  1   = RX not full
//  host_out_data          out  DW  head of TX FIFO
//  host_out_valid         out  1   = TX not empty
//  host_out_ready         in   1   host pop; transfer when valid & ready
//  dropped                out  1   sticky: a request arrived while the FSM was not IDLE
// BEHAVIOUR
//  Reset (async, any time): FSM -> IDLE; both FIFOs emptied; timer = 0.
//   All outputs 0, except host_in_ready = 1.
//  FSM states: IDLE, WAIT_TX, WAIT_RX, RESP.
//   IDLE: sample request when to_peripheral_valid=1 and code != 00. Latch code and data.
//    WRITE, TX not full  -> push word, go to RESP (ACK).
//    WRITE, TX full      -> WAIT_TX.
//    READ, RX not empty  -> pop word, go to RESP (DATA, popped word).
//    READ, RX empty      -> WAIT_RX, timer = 0.
//    STATUS              -> RESP (DATA, status word).
//   WAIT_TX: when TX not full (including same-cycle host pop), push latched word -> RESP (ACK).
//   WAIT_RX: timer increments each cycle.
//    If RX not empty (a host push in the same cycle counts) -> pop, RESP (DATA).
//    Else if timer == TIMEOUT-1 -> RESP (ERROR, data 0).
//   RESP: from_peripheral_valid=1 for exactly one cycle with latched code/data, then IDLE.
//    Outside RESP, from_peripheral_valid=0 and from_peripheral / from_peripheral_data hold 0.
//  Latency: WRITE with space, READ with data, STATUS -> response in the cycle after the
//   request edge (1 cycle). No new request is accepted in the RESP cycle.
//  Requests with valid=1 in any state other than IDLE are discarded and set dropped=1.
//   dropped clears only on reset. Code 00 with valid=1 is ignored silently.
//  FIFOs: binary read/write pointers of log2(DEPTH) bits wrap mod DEPTH; count is
//   log2(DEPTH)+1 bits. Push and pop in the same cycle leaves count unchanged,
//   including at full or empty (at empty, pop is suppressed unless valid).
//   RX push accepted only when host_in_ready=1, so an RX push is never accepted while full.
//   host_out_data is combinational from the TX head entry.
//  Status word: [31:16] = RX count, [15:0] = TX count, each zero-extended.
//   It is sampled in the IDLE cycle the request is accepted.
// TESTING
//  1 WRITE 0xDEADBEEF, TX empty -> next cycle: from_peripheral=01, valid=1;
//    host_out_valid=1, host_out_data=0xDEADBEEF.
//  2 Host pushes 0x12345678, then READ -> next cycle: code 10, data 0x12345678; RX count 0.
//  3 TIMEOUT=8, RX empty, READ -> ERROR (11, data 0) exactly 9 cycles after request;
//    variant with a host push at cycle 5 -> DATA response instead.
//  4 host_out_ready=0: four WRITEs fill TX; fifth WRITE waits in WAIT_TX.
//    Raise ready -> ACK one cycle after the first pop; words come out in order.
//  5 Two TX and three RX words buffered, then STATUS -> data 0x00030002.
//    A second request during RESP sets dropped=1 and gets no response.
//  6 Assert reset while in WAIT_RX -> outputs 0 immediately, FIFOs empty.
//    After reset, WRITE behaves as in scenario 1.

Source files
------------

// File: rtl/peripheral_responder.sv
// Peripheral endpoint of the core I/O port: serves WRITE/READ/STATUS requests
// through a TX FIFO (towards the host) and an RX FIFO (from the host).

module peripheral_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    // An empty FIFO forwards the word being pushed this cycle so push+pop can bypass.
    assign pop_data = empty ? push_data : mem[rd_ptr_reg];
endmodule

module peripheral_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    input  logic [DATA_WIDTH-1:0] host_in_data,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,
    output logic [DATA_WIDTH-1:0] host_out_data,
    output logic                  host_out_valid,
    input  logic                  host_out_ready,
    output logic                  dropped
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_TX = 2'd1;
    localparam logic [1:0] WAIT_RX = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam logic [1:0] REQ_WRITE  = 2'b01;
    localparam logic [1:0] REQ_READ   = 2'b10;
    localparam logic [1:0] REQ_STATUS = 2'b11;
    localparam logic [1:0] RSP_ACK    = 2'b01;
    localparam logic [1:0] RSP_DATA   = 2'b10;
    localparam logic [1:0] RSP_ERROR  = 2'b11;

    logic [1:0]            state_reg, state_next;
    logic [TW-1:0]         timer_reg, timer_next;
    logic [DATA_WIDTH-1:0] req_data_reg;
    logic [1:0]            resp_code_reg, resp_code_next;
    logic [DATA_WIDTH-1:0] resp_data_reg, resp_data_next;
    logic                  resp_load;
    logic                  req_load;
    logic                  dropped_reg;

    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_WIDTH-1:0] tx_push_data, tx_head;
    logic [CW-1:0]         tx_count;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0] rx_pop_data;
    logic [CW-1:0]         rx_count;
    logic [DATA_WIDTH-1:0] status_word;
    logic                  req_fire;

    assign req_fire     = to_peripheral_valid && (to_peripheral != 2'b00);
    assign tx_pop       = host_out_ready && !tx_empty;
    assign rx_push      = host_in_valid && !rx_full;
    assign tx_push_data = (state_reg == IDLE) ? to_peripheral_data : req_data_reg;

    peripheral_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    peripheral_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (host_in_data),
        .pop       (rx_pop),
        .pop_data  (rx_pop_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        status_word             = '0;
        status_word[CW-1:0]     = tx_count;
        status_word[16 +: CW]   = rx_count;
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        tx_push        = 1'b0;
        rx_pop         = 1'b0;
        req_load       = 1'b0;
        resp_load      = 1'b0;
        resp_code_next = 2'b00;
        resp_data_next = '0;
        case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    req_load = 1'b1;
                    case (to_peripheral)
                        REQ_WRITE: begin
                            if (!tx_full) begin
                                tx_push        = 1'b1;
                                resp_load      = 1'b1;
                                resp_code_next = RSP_ACK;
                                state_next     = RESP;
                            end else begin
                                state_next = WAIT_TX;
                            end
                        end
                        REQ_READ: begin
                            if (!rx_empty) begin
                                rx_pop         = 1'b1;
                                resp_load      = 1'b1;
                                resp_code_next = RSP_DATA;
                                resp_data_next = rx_pop_data;
                                state_next     = RESP;
                            end else begin
                                timer_next = '0;
                                state_next = WAIT_RX;
                            end
                        end
                        default: begin
                            resp_load      = 1'b1;
                            resp_code_next = RSP_DATA;
                            resp_data_next = status_word;
                            state_next     = RESP;
                        end
                    endcase
                end
            end
            WAIT_TX: begin
                // A host pop in this cycle frees the slot the pending word lands in.
                if (!tx_full || tx_pop) begin
                    tx_push        = 1'b1;
                    resp_load      = 1'b1;
                    resp_code_next = RSP_ACK;
                    state_next     = RESP;
                end
            end
            WAIT_RX: begin
                timer_next = timer_reg + TW'(1);
                if (!rx_empty || rx_push) begin
                    rx_pop         = 1'b1;
                    resp_load      = 1'b1;
                    resp_code_next = RSP_DATA;
                    resp_data_next = rx_pop_data;
                    state_next     = RESP;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    resp_load      = 1'b1;
                    resp_code_next = RSP_ERROR;
                    state_next     = RESP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            req_data_reg  <= '0;
            resp_code_reg <= 2'b00;
            resp_data_reg <= '0;
            dropped_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            if (req_load) begin
                req_data_reg <= to_peripheral_data;
            end
            // Response registers are non-zero only while the FSM sits in RESP.
            if (resp_load) begin
                resp_code_reg <= resp_code_next;
                resp_data_reg <= resp_data_next;
            end else if (state_reg == RESP) begin
                resp_code_reg <= 2'b00;
                resp_data_reg <= '0;
            end
            if (req_fire && (state_reg != IDLE)) begin
                dropped_reg <= 1'b1;
            end
        end
    end

    assign from_peripheral       = resp_code_reg;
    assign from_peripheral_data  = resp_data_reg;
    assign from_peripheral_valid = (state_reg == RESP);
    assign host_in_ready         = !rx_full;
    assign host_out_valid        = !tx_empty;
    assign host_out_data         = tx_empty ? '0 : tx_head;
    assign dropped               = dropped_reg;
endmodule

// File: tb/tb_peripheral_responder.sv
// Directed bench for peripheral_responder: responses and host-side TX words
// are matched against scoreboard queues filled when stimulus is driven.

module tb_peripheral_responder;
    localparam logic [1:0] REQ_WRITE  = 2'b01;
    localparam logic [1:0] REQ_READ   = 2'b10;
    localparam logic [1:0] REQ_STATUS = 2'b11;
    localparam logic [1:0] RSP_ACK    = 2'b01;
    localparam logic [1:0] RSP_DATA   = 2'b10;
    localparam logic [1:0] RSP_ERROR  = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  to_peripheral = 2'b00;
    logic [31:0] to_peripheral_data = '0;
    logic        to_peripheral_valid = 1'b0;
    logic [1:0]  from_peripheral;
    logic [31:0] from_peripheral_data;
    logic        from_peripheral_valid;
    logic [31:0] host_in_data = '0;
    logic        host_in_valid = 1'b0;
    logic        host_in_ready;
    logic [31:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready = 1'b0;
    logic        dropped;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] data;
        logic        chk_data;
        int          at;
    } exp_t;

    exp_t        rsp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] wv[5];
    logic [31:0] rv[3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    peripheral_responder #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .to_peripheral         (to_peripheral),
        .to_peripheral_data    (to_peripheral_data),
        .to_peripheral_valid   (to_peripheral_valid),
        .from_peripheral       (from_peripheral),
        .from_peripheral_data  (from_peripheral_data),
        .from_peripheral_valid (from_peripheral_valid),
        .host_in_data          (host_in_data),
        .host_in_valid         (host_in_valid),
        .host_in_ready         (host_in_ready),
        .host_out_data         (host_out_data),
        .host_out_valid        (host_out_valid),
        .host_out_ready        (host_out_ready),
        .dropped               (dropped)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at the drive point (#1 after an edge); extra = cycles beyond the 1-cycle latency.
    task automatic expect_rsp(input logic [1:0] code, input logic [31:0] data,
                              input logic chk_data, input int extra);
        exp_t e;
        e.code     = code;
        e.data     = data;
        e.chk_data = chk_data;
        e.at       = cyc + 1 + extra;
        rsp_q.push_back(e);
    endtask

    task automatic send(input logic [1:0] code, input logic [31:0] data);
        to_peripheral       = code;
        to_peripheral_data  = data;
        to_peripheral_valid = 1'b1;
        @(posedge clock); #1;
        to_peripheral_valid = 1'b0;
        to_peripheral       = 2'b00;
        to_peripheral_data  = '0;
    endtask

    task automatic host_push(input logic [31:0] data);
        host_in_valid = 1'b1;
        host_in_data  = data;
        @(posedge clock); #1;
        host_in_valid = 1'b0;
        host_in_data  = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
        check("drain_responses", 64'(rsp_q.size()), 64'd0);
        rsp_q.delete();
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset === 1'b0) begin
            if (from_peripheral_valid === 1'b1) begin
                $display("resp code=%0d data=%h cyc=%0d", from_peripheral, from_peripheral_data, cyc);
                if (rsp_q.size() == 0) begin
                    check("spurious_resp", 64'(from_peripheral_valid), 64'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("resp_code", 64'(from_peripheral), 64'(e.code));
                    if (e.chk_data) check("resp_data", 64'(from_peripheral_data), 64'(e.data));
                    check("resp_cycle", 64'(cyc), 64'(e.at));
                end
            end else begin
                check("idle_resp_zero", {30'd0, from_peripheral, from_peripheral_data}, 64'd0);
            end
            if (host_out_valid === 1'b1 && host_out_ready === 1'b1) begin
                $display("host_out data=%h cyc=%0d", host_out_data, cyc);
                if (tx_q.size() == 0) check("spurious_tx", 64'(host_out_valid), 64'd0);
                else check("tx_word", 64'(host_out_data), 64'(tx_q.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"},     64'(from_peripheral), 64'd0);
        check({tag, "_data"},     64'(from_peripheral_data), 64'd0);
        check({tag, "_valid"},    64'(from_peripheral_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(host_in_ready), 64'd1);
        check({tag, "_out_valid"},64'(host_out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(host_out_data), 64'd0);
        check({tag, "_dropped"},  64'(dropped), 64'd0);
    endtask

    initial begin
        wv[0] = 32'h1111_0001; wv[1] = 32'h2222_0002; wv[2] = 32'h3333_0003;
        wv[3] = 32'h4444_0004; wv[4] = 32'h5555_0005;
        rv[0] = 32'hAAAA_0000; rv[1] = 32'hBBBB_0001; rv[2] = 32'hCCCC_0002;

        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Scenario 1: WRITE into empty TX.
        expect_rsp(RSP_ACK, 32'd0, 1'b0, 0);
        send(REQ_WRITE, 32'hDEADBEEF);
        @(negedge clock);
        check("s1_out_valid", 64'(host_out_valid), 64'd1);
        check("s1_out_data",  64'(host_out_data), 64'hDEADBEEF);
        wait_drain(4);
        tx_q.push_back(32'hDEADBEEF);
        host_out_ready = 1'b1;
        @(posedge clock); #1;
        host_out_ready = 1'b0;

        // Scenario 2: host word then READ, RX ends empty.
        host_push(32'h12345678);
        expect_rsp(RSP_DATA, 32'h12345678, 1'b1, 0);
        send(REQ_READ, 32'd0);
        wait_drain(4);
        expect_rsp(RSP_DATA, 32'h0000_0000, 1'b1, 0);
        send(REQ_STATUS, 32'd0);
        wait_drain(4);

        // Scenario 3: READ timeout, then READ rescued by a host push mid-wait.
        expect_rsp(RSP_ERROR, 32'd0, 1'b1, 8);
        send(REQ_READ, 32'd0);
        wait_drain(16);
        expect_rsp(RSP_DATA, 32'hA5A5A5A5, 1'b1, 5);
        send(REQ_READ, 32'd0);
        repeat (4) @(posedge clock);
        #1;
        host_push(32'hA5A5A5A5);
        wait_drain(8);

        // Scenario 4: fill TX, fifth WRITE stalls until the host pops.
        for (int i = 0; i < 4; i++) begin
            expect_rsp(RSP_ACK, 32'd0, 1'b0, 0);
            send(REQ_WRITE, wv[i]);
            wait_drain(4);
        end
        send(REQ_WRITE, wv[4]);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("s4_full_in_ready", 64'(host_in_ready), 64'd1);
        check("s4_head", 64'(host_out_data), 64'(wv[0]));
        @(posedge clock); #1;
        expect_rsp(RSP_ACK, 32'd0, 1'b0, 0);
        for (int i = 0; i < 5; i++) tx_q.push_back(wv[i]);
        host_out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        host_out_ready = 1'b0;
        wait_drain(4);
        check("s4_tx_drained", 64'(tx_q.size()), 64'd0);
        @(negedge clock);
        check("s4_out_valid", 64'(host_out_valid), 64'd0);
        @(posedge clock); #1;

        // Scenario 5: STATUS with 2 TX / 3 RX words; request during RESP is dropped.
        expect_rsp(RSP_ACK, 32'd0, 1'b0, 0);
        send(REQ_WRITE, 32'h0BAD_0001);
        wait_drain(4);
        expect_rsp(RSP_ACK, 32'd0, 1'b0, 0);
        send(REQ_WRITE, 32'h0BAD_0002);
        wait_drain(4);
        for (int i = 0; i < 3; i++) host_push(rv[i]);
        expect_rsp(RSP_DATA, 32'h0003_0002, 1'b1, 0);
        send(REQ_STATUS, 32'd0);
        send(REQ_READ, 32'd0);
        wait_drain(4);
        @(negedge clock);
        check("s5_dropped", 64'(dropped), 64'd1);
        @(posedge clock); #1;
        expect_rsp(RSP_DATA, 32'h0003_0002, 1'b1, 0);
        send(REQ_STATUS, 32'd0);
        wait_drain(4);
        for (int i = 0; i < 3; i++) begin
            expect_rsp(RSP_DATA, rv[i], 1'b1, 0);
            send(REQ_READ, 32'd0);
            wait_drain(4);
        end

        // Scenario 6: reset while waiting for RX data.
        send(REQ_READ, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("s6_pre_out_valid", 64'(host_out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("s6_reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        expect_rsp(RSP_ACK, 32'd0, 1'b0, 0);
        send(REQ_WRITE, 32'hCAFEF00D);
        @(negedge clock);
        check("s6_out_valid", 64'(host_out_valid), 64'd1);
        check("s6_out_data",  64'(host_out_data), 64'hCAFEF00D);
        wait_drain(4);
        expect_rsp(RSP_DATA, 32'h0000_0001, 1'b1, 0);
        send(REQ_STATUS, 32'd0);
        wait_drain(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
